muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width; legal values are even and >= 4.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1, meaning request a new operation.
REQ-005 The block SHALL have port op, input, 2, meaning 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, meaning operands (a = multiplicand/dividend, b = multiplier/divisor).
REQ-007 The block SHALL have ports hi_we and lo_we, input, 1 each, meaning MTHI/MTLO write enables.
REQ-008 The block SHALL have port wdata, input, WIDTH, meaning MTHI/MTLO write data.
REQ-009 The block SHALL have port busy, output, 1, meaning an operation is in progress; the pipeline stalls MFHI/MFLO on it.
REQ-010 The block SHALL have port done, output, 1, meaning a one-cycle pulse when HI/LO hold a new result.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH each, meaning the registered HI/LO contents.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and FIX; busy = (state != IDLE), decoded from state only.
REQ-013 In IDLE, start=1 SHALL latch a, b and op, load the iteration counter with WIDTH, and enter CALC at that edge.
REQ-014 start SHALL be ignored whenever busy=1; no queuing.
REQ-015 For signed ops, CALC SHALL operate on magnitudes |a| and |b|; unsigned ops use the raw operands.
REQ-016 Multiply SHALL use radix-2 shift-add: one partial-product bit per CALC cycle, 2*WIDTH-bit accumulator.
REQ-017 Divide SHALL use restoring division: one quotient bit per CALC cycle.
REQ-018 CALC SHALL last exactly WIDTH cycles, then move to FIX.
REQ-019 FIX SHALL last one cycle; the sign correction SHALL be applied there.
  - Multiply: negate the 2*WIDTH product when sign(a) ^ sign(b).
  - Divide: quotient sign = sign(a) ^ sign(b); remainder sign = sign(a).
REQ-020 At the FIX exit edge the block SHALL write the result and return to IDLE.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
REQ-021 done SHALL be registered and equal 1 for exactly the one cycle following the FIX exit edge; at all other times done = 0.
REQ-022 Latency: start sampled at edge k SHALL give busy=1 for exactly WIDTH+1 cycles, with HI/LO updated and done=1 after edge k+WIDTH+1.
REQ-023 Divide by zero SHALL take the normal latency and produce HI = a (unmodified dividend) and LO = all ones, with no exception.
REQ-024 Signed DIV of MIN by -1 SHALL produce LO = MIN and HI = 0.
REQ-025 hi_we/lo_we SHALL write wdata into HI/LO only when busy=0; writes while busy=1 are dropped.
REQ-026 When hi_we/lo_we coincide with an accepted start, the write SHALL take effect, and the later result SHALL overwrite it.
REQ-027 hi and lo SHALL change only on a write (REQ-025/026), at the FIX exit edge, or on reset.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for a clock edge, force state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, and clear the counter and the internal datapath registers.
REQ-029 reset asserted mid-operation SHALL abort the operation with no HI/LO update.
REQ-030 The first start sampled after reset deasserts SHALL be accepted normally.

Verification (WIDTH=32)
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles; done a single pulse.
REQ-032 MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 DIVU a=100 b=0 -> HI=0x00000064, LO=0xFFFFFFFF after 33 cycles; DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 Busy-period inputs: start pulsed during cycle 5 of a MULTU -> no effect, result unchanged; hi_we with wdata=0x1234 during busy -> HI unaffected; hi_we when idle -> HI=0x1234 next cycle.
REQ-035 Reset mid-operation: reset asserted asynchronously 10 cycles into a DIV -> busy, done, hi and lo become 0 immediately, with no done pulse; a following MULTU 6*7 -> LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fixup in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_signed;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_diff;
    logic                 w_q_bit;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Operand conditioning: op[0]=0 selects the signed variants.
    assign w_signed = ~op[0];
    assign w_sa     = w_signed & a[WIDTH-1];
    assign w_sb     = w_signed & b[WIDTH-1];
    assign w_mag_a  = w_sa ? -a : a;
    assign w_mag_b  = w_sb ? -b : b;

    // Multiply step: acc = {partial, remaining multiplier bits}, add multiplicand on LSB then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}, shift left and try subtracting the divisor.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_b});
    assign w_div_step = {(w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_q_bit};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Sign-corrected result presented during FIX; r_a keeps the raw dividend for divide-by-zero.
    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b == {WIDTH{1'b0}}) begin
                w_res_hi = r_a;
                w_res_lo = {WIDTH{1'b1}};
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = CALC;
                end else begin
                    w_next = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_next = FIX;
                end else begin
                    w_next = CALC;
                end
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand latch and iterative datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt    <= CW'(WIDTH);
                        r_a      <= op[1] ? a : w_mag_a;
                        r_b      <= w_mag_b;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_is_div <= op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // HI/LO: result at FIX exit, otherwise MTHI/MTLO writes only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= {WIDTH{1'b0}};
            r_lo <= {WIDTH{1'b0}};
        end else if (r_state == FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state == IDLE) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
        end
    end

    // Completion pulse, one cycle after the FIX exit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint     sx;
        longint     sy;
        longint     q;
        longint     r;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] res;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'h0, x};
        uy = {32'h0, y};
        res = 64'h0;
        if (o[1] && y == 32'h0) begin
            res = {x, 32'hFFFFFFFF};
        end else begin
            case (o)
                2'b00: res = sx * sy;
                2'b01: res = ux * uy;
                2'b10: begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
                default: begin
                    q = longint'(ux / uy);
                    r = longint'(ux % uy);
                    res = {r[31:0], q[31:0]};
                end
            endcase
        end
        return res;
    endfunction

    // inj: 0 none, 1 start pulse mid-op, 2 hi_we mid-op, 3 lo_we together with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
        logic [63:0] expv;
        int n;
        int pulses;
        expv = ref_op(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (inj == 3) begin
            lo_we = 1'b1;
            wdata = 32'h5555AAAA;
        end
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        if (inj == 3) check("mtlo_with_start", {32'h0, lo}, {32'h0, 32'h5555AAAA});
        n = 0;
        pulses = 0;
        while (busy === 1'b1 && n < 100) begin
            if (done !== 1'b0) pulses++;
            n++;
            if (n == 5 && inj == 1) begin
                start = 1'b1; op = 2'b11; a = $urandom; b = $urandom;
            end else if (n == 5 && inj == 2) begin
                hi_we = 1'b1; wdata = 32'h1234;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0;
        check("busy_cycles", 64'(n), 64'd33);
        check("done_during_busy", 64'(pulses), 64'd0);
        check("done_pulse", {63'h0, done}, 64'd1);
        check("hi", {32'h0, hi}, {32'h0, expv[63:32]});
        check("lo", {32'h0, lo}, {32'h0, expv[31:0]});
        @(negedge clk);
        check("done_single", {63'h0, done}, 64'd0);
        check("busy_after", {63'h0, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          dp;

        #3;
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_done", {63'h0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check("multu_max_hi", {32'h0, hi}, {32'h0, 32'hFFFFFFFE});
        check("multu_max_lo", {32'h0, lo}, {32'h0, 32'h00000001});

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 0);
        check("mult_neg_hi", {32'h0, hi}, {32'h0, 32'hFFFFFFFF});
        check("mult_neg_lo", {32'h0, lo}, {32'h0, 32'hFFFFFFEB});

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        check("div_neg_lo", {32'h0, lo}, {32'h0, 32'hFFFFFFFD});
        check("div_neg_hi", {32'h0, hi}, {32'h0, 32'hFFFFFFFF});

        run_op(2'b11, 32'd100, 32'd0, 0);
        check("divu_zero_hi", {32'h0, hi}, {32'h0, 32'h00000064});
        check("divu_zero_lo", {32'h0, lo}, {32'h0, 32'hFFFFFFFF});

        run_op(2'b10, 32'hFFFFFF9C, 32'd0, 0);
        check("div_zero_hi", {32'h0, hi}, {32'h0, 32'hFFFFFF9C});

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_min_lo", {32'h0, lo}, {32'h0, 32'h80000000});
        check("div_min_hi", {32'h0, hi}, 64'h0);

        run_op(2'b01, 32'h00012345, 32'h00006789, 1);
        run_op(2'b01, 32'hDEADBEEF, 32'h00000003, 2);
        check("mthi_busy_dropped", {32'h0, hi}, {32'h0, 32'h00000002});

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", {32'h0, hi}, {32'h0, 32'h1234});
        lo_we = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", {32'h0, lo}, {32'h0, 32'hCAFEF00D});
        check("mtlo_keeps_hi", {32'h0, hi}, {32'h0, 32'h1234});

        run_op(2'b11, 32'd1000, 32'd7, 3);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) ry = 32'hFFFFFFFF;
            if ($urandom_range(0, 7) == 0) rx = 32'h80000000;
            run_op(ro, rx, ry, 0);
        end

        // Asynchronous reset ten cycles into a DIV
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'h12345678; b = 32'hFFFFFFF3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {63'h0, busy}, 64'd0);
        check("arst_done", {63'h0, done}, 64'd0);
        check("arst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        dp = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dp++;
        end
        check("no_activity_after_abort", 64'(dp), 64'd0);
        check("hilo_after_abort", {hi, lo}, 64'h0);

        run_op(2'b01, 32'd6, 32'd7, 0);
        check("multu_6x7_lo", {32'h0, lo}, 64'd42);
        check("multu_6x7_hi", {32'h0, hi}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
